adder_serial_nbit: RTL and testbench
====================================

# adder_serial_nbit

Parametrised multi-cycle adder/subtractor built from full-adder cells. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, keeping a registered carry between chunks, and reports carry-out and signed overflow. It sits beside the combinational 1-bit and N-bit adders and serves area-constrained datapaths that can accept fixed multi-cycle latency under a start/busy/done handshake.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- carry_in  in  1  carry into bit 0; ignored when sub=1.
- sub  in  1  0 = a+b+carry_in; 1 = a−b, computed as a + ~b + 1.
- sum  out  WIDTH  registered result; holds until the next done.
- carry_out  out  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high while in CALC.
- done  out  1  single-cycle pulse when the result becomes valid.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: on start=1, capture a, b ^ {WIDTH{sub}}, and cin = sub ? 1 : carry_in into working registers. Clear the chunk counter and go to CALC.
- CALC: each cycle, process chunk idx = count (bits [idx*CHUNK +: CHUNK]).
  - Write the chunk sum into the working result register.
  - Register the chunk carry as the carry for the next chunk.
  - On the final chunk (count = NCHUNK−1), also latch the carry into the MSB.
  - On that final edge, copy the working result to sum, the final carry to carry_out, and the overflow to overflow, then go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation; next state CALC).
  - Otherwise return to IDLE.
- start during CALC is ignored and does not queue.
- Operand inputs are don't-care except on the accepted start edge.
- Simulation-only checks: start, sub, and carry_in are 0/1 (no X/Z) when sampled; rst is never X after time 0. Violations raise $error.
- CHUNK=WIDTH is legal: one CALC cycle.

## Timing
- Reset: sum=0, carry_out=0, overflow=0, busy=0, done=0, state=IDLE, counter=0, working registers=0.
- rst high on any edge overrides everything, including mid-CALC. The partial result is discarded; there is no done for the aborted operation.
- Start accepted at edge E0 → busy high from E0 through E_NCHUNK (NCHUNK cycles).
- sum, carry_out, overflow, and done update at E_NCHUNK; done deasserts at E_NCHUNK+1 unless the design returns to DONE.
- Latency is NCHUNK+1 cycles from the start assertion cycle to the done-high cycle; throughput is one result per NCHUNK+1 cycles.
- sum, carry_out, and overflow change only on the completion edge or on reset. They are stable throughout CALC of a following operation.
- No combinational path from inputs to outputs.

## Structure
- Package adder_pkg: state_t enum {IDLE, CALC, DONE} as a 2-bit logic enum.
- Sub-module adder_chunk, parameter CHUNK: a combinational ripple of CHUNK full-adder cells.
  - Ports: a, b, cin; sum, cout, c_msb (carry into its top bit).
  - Instantiated once, fed by a counter-selected slice.
- Elaboration-time checks: $error if WIDTH % CHUNK ≠ 0 or CHUNK < 1.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless noted.
- a=0x1234, b=0x4321, cin=0, sub=0, start 1 cycle → busy 4 cycles; done on the 5th cycle after start; sum=0x5555, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, carry_out=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, carry_out=0, overflow=1.
- sub=1, carry_in=1 (ignored), a=0x0005, b=0x0007 → sum=0xFFFE, carry_out=0, overflow=0. Then a=0x8000, b=0x0001 → sum=0x7FFF, carry_out=1, overflow=1.
- start held high continuously with new operands each accept → second start ignored in CALC, accepted in the DONE cycle; done pulses every 5 cycles; previous sum holds until each new done.
- rst asserted on the 2nd CALC cycle → next cycle all outputs 0, busy=0, no done. A subsequent 0x0001+0x0001 returns sum=0x0002.
- Sweep CHUNK ∈ {1, 4, 16} with 1000 random operands each → results match a+b+cin and a−b; latency = NCHUNK+1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the serial adder/subtractor: the controller state encoding.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple of CHUNK full-adder cells; also exposes the carry into
// the top cell so the caller can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic ripple;

  // A scalar ripple variable avoids a self-referencing carry vector.
  always_comb begin
    sum    = '0;
    c_msb  = 1'b0;
    ripple = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ ripple;
      if (i == CHUNK - 1) c_msb = ripple;
      ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
    end
    cout = ripple;
  end

endmodule

// File: rtl/adder_serial_nbit.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock with a
// start/busy/done handshake; results hold until the next completion.
module adder_serial_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("adder_serial_nbit: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  op_a, op_b, work, work_next;
  logic              carry;
  logic [CHUNK-1:0]  a_slice, b_slice, chunk_sum;
  logic              chunk_cout, chunk_cmsb;
  logic              accept, last;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_slice),
    .b     (b_slice),
    .cin   (carry),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    last      = (state == CALC) && (count == CW'(NCHUNK - 1));
    a_slice   = op_a[int'(count) * CHUNK +: CHUNK];
    b_slice   = op_b[int'(count) * CHUNK +: CHUNK];
    work_next = work;
    work_next[int'(count) * CHUNK +: CHUNK] = chunk_sum;
  end

  always_comb begin
    state_next = state;
    busy       = (state == CALC);
    done       = (state == DONE);
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Subtraction is folded in at capture time: invert B and force the carry in.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      work      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= sub ? 1'b1 : carry_in;
      count <= '0;
      work  <= '0;
    end else if (state == CALC) begin
      work  <= work_next;
      carry <= chunk_cout;
      count <= count + 1'b1;
      if (last) begin
        sum       <= work_next;
        carry_out <= chunk_cout;
        overflow  <= chunk_cout ^ chunk_cmsb;
      end
    end
  end

  always @(posedge clk) begin
    assert (!$isunknown(rst)) else $error("adder_serial_nbit: rst is X/Z");
    if (rst == 1'b0 && (state == IDLE || state == DONE)) begin
      assert (!$isunknown(start)) else $error("adder_serial_nbit: start is X/Z when sampled");
      if (start == 1'b1) begin
        assert (!$isunknown({sub, carry_in})) else $error("adder_serial_nbit: sub/carry_in X/Z on accept");
      end
    end
  end

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Directed and random checks of adder_serial_nbit at CHUNK = 16, 4 and 1,
// including back-to-back starts and a reset during calculation.
module tb_adder_serial_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: CHUNK=16, index 1: CHUNK=4 (main), index 2: CHUNK=1.
  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        cin_v   [3];
  logic        sub_v   [3];
  logic [15:0] sum_v   [3];
  logic        co_v    [3];
  logic        ov_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];

  int checks = 0;
  int errors = 0;

  adder_serial_nbit #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .carry_in(cin_v[0]), .sub(sub_v[0]), .sum(sum_v[0]), .carry_out(co_v[0]),
    .overflow(ov_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  adder_serial_nbit #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .carry_in(cin_v[1]), .sub(sub_v[1]), .sum(sum_v[1]), .carry_out(co_v[1]),
    .overflow(ov_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  adder_serial_nbit #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .carry_in(cin_v[2]), .sub(sub_v[2]), .sum(sum_v[2]), .carry_out(co_v[2]),
    .overflow(ov_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [9];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation on instance k and compare the completed result.
  task automatic apply_stimulus(input int k, input logic [15:0] ia, input logic [15:0] ib,
                                input logic icin, input logic isub, input int nchunk,
                                input logic [15:0] esum, input logic eco, input logic eov,
                                input string tag);
    int edges;
    @(negedge clk);
    a_v[k] = ia; b_v[k] = ib; cin_v[k] = icin; sub_v[k] = isub; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    edges = 1;
    while (done_v[k] !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check_output({tag, " latency"}, 32'(edges), 32'(nchunk + 1));
    check_output({tag, " sum"}, 32'(sum_v[k]), 32'(esum));
    check_output({tag, " carry_out"}, 32'(co_v[k]), 32'(eco));
    check_output({tag, " overflow"}, 32'(ov_v[k]), 32'(eov));
  endtask

  initial begin
    logic [15:0] ra, rb, bb;
    logic        rcin, rsub, c0;
    logic [16:0] full;
    logic        eov;
    bit          saw_done;

    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; sub_v[k] = 1'b0;
    end

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_output("reset sum", 32'(sum_v[1]), 32'h0);
    check_output("reset carry_out", 32'(co_v[1]), 32'h0);
    check_output("reset overflow", 32'(ov_v[1]), 32'h0);
    check_output("reset busy", 32'(busy_v[1]), 32'h0);
    check_output("reset done", 32'(done_v[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 4,
                     vecs[i].sum, vecs[i].co, vecs[i].ov, $sformatf("vec%0d", i));
    end

    // start held high: ignored in CALC, accepted again in the DONE cycle.
    @(negedge clk);
    a_v[1] = 16'h1111; b_v[1] = 16'h1111; cin_v[1] = 1'b0; sub_v[1] = 1'b0; start_v[1] = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      check_output($sformatf("b2b done e%0d", e), 32'(done_v[1]), 32'((e == 4) || (e == 9)));
      if (e >= 4 && e <= 8) check_output($sformatf("b2b sum e%0d", e), 32'(sum_v[1]), 32'h2222);
      if (e == 9) check_output("b2b sum second", 32'(sum_v[1]), 32'h0300);
      if (e == 5) check_output("b2b busy restart", 32'(busy_v[1]), 32'h1);
      if (e == 1) begin
        a_v[1] = 16'h0100; b_v[1] = 16'h0200;
      end
      if (e == 9) start_v[1] = 1'b0;
    end

    // Reset during the second CALC cycle discards the operation.
    @(negedge clk);
    a_v[1] = 16'h00FF; b_v[1] = 16'h0001; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("abort sum", 32'(sum_v[1]), 32'h0);
    check_output("abort carry_out", 32'(co_v[1]), 32'h0);
    check_output("abort overflow", 32'(ov_v[1]), 32'h0);
    check_output("abort busy", 32'(busy_v[1]), 32'h0);
    check_output("abort done", 32'(done_v[1]), 32'h0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_v[1] !== 1'b0) saw_done = 1'b1;
    end
    check_output("abort no done", 32'(saw_done), 32'h0);
    apply_stimulus(1, 16'h0001, 16'h0001, 1'b0, 1'b0, 4, 16'h0002, 1'b0, 1'b0, "post-abort");

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rsub = 1'($urandom_range(0, 1));
        rcin = 1'($urandom_range(0, 1));
        bb   = rsub ? ~rb : rb;
        c0   = rsub ? 1'b1 : rcin;
        full = {1'b0, ra} + {1'b0, bb} + {16'h0, c0};
        eov  = (ra[15] == bb[15]) && (full[15] != ra[15]);
        apply_stimulus(k, ra, rb, rcin, rsub, (k == 0) ? 1 : ((k == 1) ? 4 : 16),
                       full[15:0], full[16], eov, $sformatf("rand k%0d n%0d", k, n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
